nmea_field_parser: RTL and testbench

//  Generic NMEA-0183 sentence parser fed by the uart_rx byte stream. Matches one

---
 rtl/nmea_field_parser.sv | 219 +++++++++++++++++++++
 tb/tb_nmea_field_parser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nmea_field_parser.sv
// NMEA-0183 sentence parser: matches one sentence ID, captures selected comma fields
// into a double-banked character RAM and publishes a bank only after a good *hh checksum.
module nmea_field_parser #(
  parameter logic [39:0] SENT_ID   = 40'h474E524D43,
  parameter int          NUM_SLOTS = 4,
  parameter logic [19:0] FIELD_IDX = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter int          LEN_W     = 4,
  parameter logic [7:0]  PAD_CHAR  = 8'h20,
  parameter logic [4:0]  VALID_FLD = 5'd2,
  parameter logic [7:0]  VALID_CHR = 8'h41
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [LEN_W+2:0] ram_addr,
  output logic [7:0]       ram_data,
  output logic             ram_we,
  output logic             rd_bank,
  output logic             frame_done,
  output logic             chk_ok,
  output logic             fix_valid,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, ID, BODY, PAD, CK1, CK2} state_t;

  localparam logic [LEN_W:0] FULL = (LEN_W+1)'(2**LEN_W);

  state_t         state, resume;
  logic [2:0]     id_cnt;
  logic [4:0]     fld;
  logic [7:0]     chk;
  logic [LEN_W:0] char_cnt;
  logic [1:0]     pad_slot;
  logic [3:0]     ck_hi;
  logic           pending;
  logic           wr_bank;
  logic           skid_vld;
  logic [7:0]     skid_data;

  logic           bv;
  logic [7:0]     b;
  logic [7:0]     id_exp;
  logic           hit;
  logic [1:0]     hit_slot;
  logic           b_hex;
  logic [3:0]     b_nib;

  // Outside PAD the skid byte, if any, always goes first.
  always_comb begin
    bv = skid_vld | rx_valid;
    b  = skid_vld ? skid_data : rx_data;
  end

  always_comb begin
    case (id_cnt)
      3'd0:    id_exp = SENT_ID[39:32];
      3'd1:    id_exp = SENT_ID[31:24];
      3'd2:    id_exp = SENT_ID[23:16];
      3'd3:    id_exp = SENT_ID[15:8];
      default: id_exp = SENT_ID[7:0];
    endcase
  end

  always_comb begin
    hit      = 1'b0;
    hit_slot = 2'd0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (FIELD_IDX[5*s +: 5] == fld) begin
        hit      = 1'b1;
        hit_slot = 2'(s);
      end
    end
  end

  always_comb begin
    b_hex = ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46));
    b_nib = (b <= 8'h39) ? 4'(b - 8'h30) : 4'(b - 8'h37);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resume     <= BODY;
      id_cnt     <= '0;
      fld        <= '0;
      chk        <= '0;
      char_cnt   <= '0;
      pad_slot   <= '0;
      ck_hi      <= '0;
      pending    <= 1'b0;
      wr_bank    <= 1'b1;
      skid_vld   <= 1'b0;
      skid_data  <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_we     <= 1'b0;
      rd_bank    <= 1'b0;
      frame_done <= 1'b0;
      chk_ok     <= 1'b0;
      fix_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (state == PAD) begin
        ram_we   <= 1'b1;
        ram_addr <= {wr_bank, pad_slot, char_cnt[LEN_W-1:0]};
        ram_data <= PAD_CHAR;
        if (char_cnt == FULL - 1'b1) begin
          state    <= resume;
          char_cnt <= '0;
        end else begin
          char_cnt <= char_cnt + 1'b1;
        end
        if (rx_valid) begin
          if (skid_vld) begin
            err      <= 1'b1;
            state    <= IDLE;
            skid_vld <= 1'b0;
            char_cnt <= '0;
          end else begin
            skid_vld  <= 1'b1;
            skid_data <= rx_data;
          end
        end
      end else if (bv) begin
        // A fresh byte arriving while the skid drains takes the skid's place.
        if (skid_vld) begin
          skid_vld  <= rx_valid;
          skid_data <= rx_data;
        end
        if (b == 8'h24) begin
          state    <= ID;
          id_cnt   <= '0;
          chk      <= '0;
          pending  <= 1'b0;
          char_cnt <= '0;
        end else begin
          case (state)
            ID: begin
              chk <= chk ^ b;
              if (id_cnt == 3'd5) begin
                if (b == 8'h2C) begin
                  state    <= BODY;
                  fld      <= 5'd1;
                  char_cnt <= '0;
                end else begin
                  state <= IDLE;
                end
              end else if (b == id_exp) begin
                id_cnt <= id_cnt + 1'b1;
              end else begin
                state <= IDLE;
              end
            end
            BODY: begin
              if (b == 8'h2A || b == 8'h2C) begin
                if (b == 8'h2C) begin
                  chk <= chk ^ b;
                  if (fld != 5'd31) fld <= fld + 1'b1;
                end
                if (hit && char_cnt != FULL) begin
                  state    <= PAD;
                  resume   <= (b == 8'h2A) ? CK1 : BODY;
                  pad_slot <= hit_slot;
                end else begin
                  state    <= (b == 8'h2A) ? CK1 : BODY;
                  char_cnt <= '0;
                end
              end else if (b == 8'h0D || b == 8'h0A) begin
                err   <= 1'b1;
                state <= IDLE;
              end else begin
                chk <= chk ^ b;
                if (fld == VALID_FLD && char_cnt == '0) pending <= (b == VALID_CHR);
                if (char_cnt != FULL) begin
                  char_cnt <= char_cnt + 1'b1;
                  if (hit) begin
                    ram_we   <= 1'b1;
                    ram_addr <= {wr_bank, hit_slot, char_cnt[LEN_W-1:0]};
                    ram_data <= b;
                  end
                end
              end
            end
            CK1: begin
              if (b_hex) begin
                ck_hi <= b_nib;
                state <= CK2;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
            CK2: begin
              state <= IDLE;
              if (b_hex) begin
                frame_done <= 1'b1;
                chk_ok     <= ({ck_hi, b_nib} == chk);
                if ({ck_hi, b_nib} == chk) begin
                  rd_bank   <= wr_bank;
                  wr_bank   <= ~wr_bank;
                  fix_valid <= pending;
                end
              end else begin
                err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nmea_field_parser.sv
// Directed bench for nmea_field_parser: a negedge monitor mirrors RAM writes and pulse
// counts; each step compares against hand-derived slot contents and flags.
module tb_nmea_field_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [6:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       rd_bank;
  logic       frame_done;
  logic       chk_ok;
  logic       fix_valid;
  logic       err;

  nmea_field_parser dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .rd_bank(rd_bank), .frame_done(frame_done), .chk_ok(chk_ok),
    .fix_valid(fix_valid), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [128];
  int wcnt [8];
  int we_cnt = 0, fd_cnt = 0, er_cnt = 0;
  logic last_ok = 1'b0;

  initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  initial for (int i = 0; i < 8; i++) wcnt[i] = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr] = ram_data;
      wcnt[ram_addr[6:4]] = wcnt[ram_addr[6:4]] + 1;
      we_cnt = we_cnt + 1;
    end
    if (frame_done) begin
      fd_cnt  = fd_cnt + 1;
      last_ok = chk_ok;
    end
    if (err) er_cnt = er_cnt + 1;
  end

  int n_cmp = 0, n_bad = 0;
  int we0, fd0, er0;
  int w0 [8];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    we0 = we_cnt; fd0 = fd_cnt; er0 = er_cnt;
    for (int i = 0; i < 8; i++) w0[i] = wcnt[i];
  endtask

  function automatic int bank_delta(input int bk);
    int t = 0;
    for (int s = 0; s < 4; s++) t += wcnt[bk*4+s] - w0[bk*4+s];
    return t;
  endfunction

  function automatic logic [127:0] pad16(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [127:0] slot(input int bk, input int s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = mem[bk*64 + s*16 + i];
    return r;
  endfunction

  function automatic logic [7:0] xsum(input string body);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < body.len(); i++) c ^= body[i];
    return c;
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  task automatic send_byte(input logic [7:0] c, input int gap);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = c;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 20);
  endtask

  task automatic send_sentence(input string body, input logic [7:0] delta);
    logic [7:0] cs;
    cs = xsum(body) + delta;
    send_byte(8'h24, 20);
    send_str(body);
    send_byte(8'h2A, 20);
    send_byte(hexc(cs[7:4]), 20);
    send_byte(hexc(cs[3:0]), 20);
  endtask

  localparam string S1 = "GNRMC,123519.00,A,2233.1234,N,11400.5678,E";
  localparam string S4 = "GNRMC,1,V,ABCDEFGHIJKLMNOPQRST,S";
  localparam string S5 = "GNRMC,654321,A,1111.22,S";

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {ram_we, ram_addr, ram_data, rd_bank, frame_done, chk_ok, fix_valid, err}, '0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Good sentence lands in bank 1, then bank 1 is published.
    snap();
    send_sentence(S1, 8'h00);
    check("t1_frame_done", fd_cnt - fd0, 1);
    check("t1_chk_ok", last_ok, 1);
    check("t1_no_err", er_cnt - er0, 0);
    check("t1_rd_bank", rd_bank, 1);
    check("t1_fix_valid", fix_valid, 1);
    check("t1_bank1_writes", bank_delta(1), 64);
    check("t1_slot0", slot(1, 0), pad16("123519.00"));
    check("t1_slot1", slot(1, 1), pad16("A"));
    check("t1_slot2", slot(1, 2), pad16("2233.1234"));
    check("t1_slot3", slot(1, 3), pad16("N"));

    // Checksum off by one: frame ends but nothing is published.
    snap();
    send_sentence(S1, 8'h01);
    check("t2_frame_done", fd_cnt - fd0, 1);
    check("t2_chk_bad", last_ok, 0);
    check("t2_rd_bank", rd_bank, 1);
    check("t2_fix_valid", fix_valid, 1);
    check("t2_bank0_writes", bank_delta(0), 64);

    // Foreign sentence IDs are ignored entirely.
    snap();
    send_str("$GPGSV,1,1,04*7A");
    send_str("$GNRMA,1,2*00");
    check("t3_no_we", we_cnt - we0, 0);
    check("t3_no_fd", fd_cnt - fd0, 0);
    check("t3_no_err", er_cnt - er0, 0);

    // 20-char field truncated to 16; write bank 0 reused after the bad sentence.
    snap();
    send_sentence(S4, 8'h00);
    check("t4_slot2_writes", wcnt[2] - w0[2], 16);
    check("t4_slot2", slot(0, 2), pad16("ABCDEFGHIJKLMNOP"));
    check("t4_slot0", slot(0, 0), pad16("1"));
    check("t4_chk_ok", last_ok, 1);
    check("t4_rd_bank", rd_bank, 0);
    check("t4_fix_invalid", fix_valid, 0);

    // '$' mid-field aborts; only the following complete sentence commits.
    snap();
    send_str("$GNRMC,12");
    send_sentence(S5, 8'h00);
    check("t5_one_frame", fd_cnt - fd0, 1);
    check("t5_chk_ok", last_ok, 1);
    check("t5_rd_bank", rd_bank, 1);
    check("t5_fix_valid", fix_valid, 1);
    check("t5_slot0", slot(1, 0), pad16("654321"));
    check("t5_slot2", slot(1, 2), pad16("1111.22"));

    // Reset in the middle of a body.
    send_str("$GNRMC,99");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_rst_outputs", {ram_we, ram_addr, ram_data, rd_bank, frame_done, chk_ok, fix_valid, err}, '0);
    @(posedge clk); #1 rst = 1'b0;
    snap();
    send_sentence(S1, 8'h00);
    check("t5_post_rst_bank1", bank_delta(1), 64);
    check("t5_post_rst_bank0", bank_delta(0), 0);
    check("t5_post_rst_rd_bank", rd_bank, 1);

    // Two bytes on consecutive cycles during PAD: first is held, second overruns.
    snap();
    send_str("$GNRMC,1,A");
    send_byte(8'h2C, 0);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h4E;
    @(posedge clk); #1 rx_data = 8'h5A;
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (30) @(posedge clk);
    check("t6_overrun_err", er_cnt - er0, 1);
    snap();
    send_str("*00");
    check("t6_idle_no_fd", fd_cnt - fd0, 0);
    check("t6_idle_no_err", er_cnt - er0, 0);
    check("t6_rd_bank_kept", rd_bank, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
